// File: rtl/aud_sram_writer_if.sv
// Recorder write port and playback read port of aud_sram_writer.
// master = recorder/playback side, slave = the SRAM writer.
interface aud_sram_writer_if;
  logic        i_wr_valid;
  logic [19:0] i_wr_addr;
  logic [15:0] i_wr_data;
  logic        o_wr_ready;
  logic        i_rd_req;
  logic [19:0] i_rd_addr;
  logic        o_rd_ready;
  logic        o_rd_valid;
  logic [15:0] o_rd_data;
  logic        i_clr_ovf;
  logic        o_overflow;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_ovf,
    input  o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_overflow
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_ovf,
    output o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_overflow
  );
endinterface

// File: rtl/aud_sram_writer.sv
// Buffers recorder samples in a small FIFO and writes them to the async SRAM,
// interleaving single-word reads for playback. i_rst_n is active-high.
module aud_sram_writer #(
  parameter int DEPTH    = 4,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  aud_sram_writer_if.slave    bus,
  output logic [19:0]         o_SRAM_ADDR,
  inout  wire  [15:0]         io_SRAM_DQ,
  output logic                o_SRAM_WE_N,
  output logic                o_SRAM_CE_N,
  output logic                o_SRAM_OE_N,
  output logic                o_SRAM_LB_N,
  output logic                o_SRAM_UB_N
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_ent_t;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, R_DONE} state_t;

  state_t         st, st_n;
  wr_ent_t        mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    cnt;
  logic           full, empty, push, pop, drop;
  logic [TW-1:0]  tmr;
  logic           rd_pend;
  logic [19:0]    rd_addr_q;
  logic [19:0]    addr_q;
  logic [15:0]    data_q;
  logic           dq_oe;
  logic           we_n_q, ce_n_q, oe_n_q;
  logic           rd_valid_q;
  logic [15:0]    rd_data_q;
  logic           ovf_q;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push  = bus.i_wr_valid & (~full | pop);
  assign drop  = bus.i_wr_valid & full & ~pop;

  assign bus.o_wr_ready = ~full;
  assign bus.o_rd_ready = ~rd_pend;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_overflow = ovf_q;

  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign io_SRAM_DQ  = dq_oe ? data_q : 16'hzzzz;

  always_comb begin
    st_n = st;
    pop  = 1'b0;
    case (st)
      IDLE: begin
        if (full) begin
          st_n = W_SETUP;
          pop  = 1'b1;
        end else if (rd_pend) begin
          st_n = R_ACC;
        end else if (!empty) begin
          st_n = W_SETUP;
          pop  = 1'b1;
        end
      end
      W_SETUP: st_n = W_PULSE;
      W_PULSE: if (tmr == TW'(WR_PULSE - 1)) st_n = W_HOLD;
      W_HOLD:  st_n = IDLE;
      R_ACC:   if (tmr == TW'(RD_WAIT - 1)) st_n = R_DONE;
      R_DONE:  st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Pin controls are registered from the next state so WE_N/OE_N never glitch.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      st         <= IDLE;
      tmr        <= '0;
      we_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe      <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      st         <= st_n;
      tmr        <= (st_n != st) ? '0 : tmr + TW'(1);
      we_n_q     <= (st_n != W_PULSE);
      ce_n_q     <= (st_n == IDLE) || (st_n == R_DONE);
      oe_n_q     <= (st_n != R_ACC);
      dq_oe      <= (st_n == W_SETUP) || (st_n == W_PULSE) || (st_n == W_HOLD);
      rd_valid_q <= (st_n == R_DONE);
      if (pop) begin
        addr_q <= mem[rptr].addr;
        data_q <= mem[rptr].data;
      end else if (st == IDLE && st_n == R_ACC) begin
        addr_q <= rd_addr_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= '{addr: bus.i_wr_addr, data: bus.i_wr_data};
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (st == R_DONE) begin
        rd_pend <= 1'b0;
      end else if (bus.i_rd_req && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= bus.i_rd_addr;
      end
      if (st == R_ACC && st_n == R_DONE) rd_data_q <= io_SRAM_DQ;
      if (drop)                ovf_q <= 1'b1;
      else if (bus.i_clr_ovf)  ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aud_sram_writer.sv
// Directed bench for aud_sram_writer with a behavioural async SRAM on the pins.
module tb_aud_sram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;
  int          checks = 0;
  int          errors = 0;

  aud_sram_writer_if bus ();

  aud_sram_writer #(.DEPTH(4), .WR_PULSE(2), .RD_WAIT(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .bus         (bus.slave),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_CE_N (ce_n),
    .o_SRAM_OE_N (oe_n),
    .o_SRAM_LB_N (lb_n),
    .o_SRAM_UB_N (ub_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [256];
  logic [35:0] wlog [$];
  logic        prev_we = 1'b1;
  int          rdv_cnt = 0;

  assign sram_dq = (!oe_n && !ce_n) ? sram[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk)
    if (!ce_n && !we_n && !lb_n && !ub_n) sram[sram_addr[7:0]] <= sram_dq;

  // A completed write is logged when WE_N rises; ADDR/DQ are still held then.
  always @(negedge clk) begin
    if (!prev_we && we_n) wlog.push_back({sram_addr, sram_dq});
    prev_we <= we_n;
    if (bus.o_rd_valid) rdv_cnt <= rdv_cnt + 1;
    checks++;
    assert (!(we_n === 1'b0 && oe_n === 1'b0)) else begin
      errors++;
      $error("FAIL we_oe_overlap observed we_n=%b oe_n=%b expected never both 0", we_n, oe_n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] d);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
  endtask

  initial begin
    int rdv0;
    logic [5:0] rdy_exp;
    for (int i = 0; i < 256; i++) sram[i] = 16'h5A5A;
    bus.i_wr_valid = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0;
    bus.i_rd_req = 0; bus.i_rd_addr = 0; bus.i_clr_ovf = 0;
    tick(); tick();
    // reset values while still in reset
    chk("rst_ctrl", {35'd0, we_n, ce_n, oe_n, lb_n, ub_n}, 40'h1F);
    chk("rst_addr", sram_addr, 0);
    chk("rst_flags", {bus.o_wr_ready, bus.o_rd_ready, bus.o_rd_valid, bus.o_overflow}, 4'b1100);
    chk("rst_rd_data", bus.o_rd_data, 0);
    rst = 0;
    tick();

    // single write
    push(20'h00005, 16'hBEEF); tick(); bus.i_wr_valid = 0;
    chk("w1_c1_idle", {we_n, ce_n}, 2'b11);
    tick();
    chk("w1_setup", {we_n, ce_n, oe_n, lb_n, ub_n, sram_addr, sram_dq}, {5'b10100, 20'h00005, 16'hBEEF});
    tick();
    chk("w1_pulse0", {we_n, ce_n, sram_addr, sram_dq}, {2'b00, 20'h00005, 16'hBEEF});
    tick();
    chk("w1_pulse1", {we_n, ce_n, sram_addr, sram_dq}, {2'b00, 20'h00005, 16'hBEEF});
    tick();
    chk("w1_hold", {we_n, ce_n, sram_addr, sram_dq}, {2'b10, 20'h00005, 16'hBEEF});
    tick();
    chk("w1_done", {we_n, ce_n}, 2'b11);
    chk("w1_log_n", wlog.size(), 1);
    if (wlog.size() > 0) chk("w1_log", wlog[0], {20'h00005, 16'hBEEF});

    // read back, latency RD_WAIT+2
    bus.i_rd_req = 1; bus.i_rd_addr = 20'h00005; tick(); bus.i_rd_req = 0;
    chk("r1_c1", {bus.o_rd_ready, oe_n}, 2'b01);
    tick();
    chk("r1_acc0", {oe_n, we_n, ce_n, sram_addr}, {3'b010, 20'h00005});
    tick();
    chk("r1_acc1", {oe_n, bus.o_rd_valid}, 2'b00);
    tick();
    chk("r1_valid", {bus.o_rd_valid, oe_n, bus.o_rd_data}, {2'b11, 16'hBEEF});
    tick();
    chk("r1_after", {bus.o_rd_valid, bus.o_rd_ready}, 2'b01);

    // burst of 6: last one dropped
    wlog.delete();
    rdy_exp = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_rdy%0d", i), bus.o_wr_ready, rdy_exp[i]);
      push(20'h10 + 20'(i), 16'h1000 + 16'(i));
      tick();
    end
    bus.i_wr_valid = 0;
    chk("burst_ovf", bus.o_overflow, 1);
    repeat (30) tick();
    chk("burst_log_n", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk($sformatf("burst_log%0d", i), wlog[i], {20'h10 + 20'(i), 16'h1000 + 16'(i)});
    bus.i_clr_ovf = 1; tick(); bus.i_clr_ovf = 0;
    chk("burst_clr", bus.o_overflow, 0);

    // read jumps ahead of queued writes; second request ignored
    wlog.delete();
    rdv0 = rdv_cnt;
    for (int i = 0; i < 3; i++) begin
      push(20'h20 + 20'(i), 16'h2000 + 16'(i));
      tick();
    end
    bus.i_wr_valid = 0;
    bus.i_rd_req = 1; bus.i_rd_addr = 20'h00005; tick();
    bus.i_rd_addr = 20'h00099;
    chk("arb_rd_busy", bus.o_rd_ready, 0);
    tick(); bus.i_rd_req = 0;
    tick(); tick();
    chk("arb_racc", {oe_n, sram_addr}, {1'b0, 20'h00005});
    tick(); tick();
    chk("arb_rvalid", {bus.o_rd_valid, bus.o_rd_data}, {1'b1, 16'hBEEF});
    chk("arb_log_at_rd", wlog.size(), 1);
    repeat (20) tick();
    chk("arb_log_n", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk($sformatf("arb_log%0d", i), wlog[i], {20'h20 + 20'(i), 16'h2000 + 16'(i)});
    chk("arb_rdv_once", rdv_cnt - rdv0, 1);
    chk("arb_rd_ready", bus.o_rd_ready, 1);

    // full FIFO beats a pending read
    wlog.delete();
    rdv0 = rdv_cnt;
    for (int i = 0; i < 5; i++) begin
      push(20'h30 + 20'(i), 16'h3000 + 16'(i));
      if (i == 4) begin bus.i_rd_req = 1; bus.i_rd_addr = 20'h00005; end
      tick();
    end
    bus.i_wr_valid = 0; bus.i_rd_req = 0;
    chk("full_rdy", {bus.o_wr_ready, bus.o_rd_ready}, 2'b00);
    tick(); tick();
    chk("full_wfirst", {ce_n, oe_n, sram_addr}, {2'b01, 20'h00031});
    repeat (5) tick();
    chk("full_rthen", {oe_n, sram_addr}, {1'b0, 20'h00005});
    repeat (30) tick();
    chk("full_log_n", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk($sformatf("full_log%0d", i), wlog[i], {20'h30 + 20'(i), 16'h3000 + 16'(i)});
    chk("full_rdv", rdv_cnt - rdv0, 1);
    chk("full_ovf", bus.o_overflow, 0);

    // reset in the middle of a write pulse
    for (int i = 0; i < 3; i++) begin
      push(20'h40 + 20'(i), 16'h4000 + 16'(i));
      tick();
    end
    bus.i_wr_valid = 0;
    chk("rstw_pulse", we_n, 0);
    #2 rst = 1;
    #1;
    chk("rstw_async", {we_n, ce_n, oe_n, bus.o_wr_ready}, 4'b1111);
    #2 rst = 0;
    tick();
    wlog.delete();
    repeat (10) tick();
    chk("rstw_nowrite", wlog.size(), 0);
    chk("rstw_state", {ce_n, bus.o_wr_ready, bus.o_rd_ready, bus.o_overflow}, 4'b1110);
    chk("rstw_sram", sram[8'h41], 16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aud_sram_writer.md
Name: aud_sram_writer

Overview:
- Sits directly downstream of the audio recorder. It takes recorder sample/address pairs through a valid/ready port and buffers them in a small FIFO.
- It drives the board's 16-bit asynchronous SRAM with correctly timed write cycles.
- It also arbitrates a single-word read port for the playback path, so one block owns the SRAM pins.
- Runs on the audio clock domain, i_clk = BCLK.

Parameters:
- DEPTH, 4: write FIFO entries; must be a power of 2, at least 2.
- WR_PULSE, 2: cycles WE_N is held low per write.
- RD_WAIT, 2: cycles OE_N is held low before DQ is sampled.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-high. Despite the name, 1 = reset.
- i_wr_valid, in, 1: recorder presents a sample.
- i_wr_addr, in, 20: sample address.
- i_wr_data, in, 16: sample data.
- o_wr_ready, out, 1: FIFO not full.
- i_rd_req, in, 1: single-cycle read request.
- i_rd_addr, in, 20: read address, sampled with i_rd_req.
- o_rd_ready, out, 1: no read pending or in flight.
- o_rd_valid, out, 1: one-cycle pulse; o_rd_data is valid.
- o_rd_data, out, 16: last read word.
- i_clr_ovf, in, 1: clears o_overflow.
- o_overflow, out, 1: sticky; a write was dropped.
- o_SRAM_ADDR, out, 20: SRAM address.
- io_SRAM_DQ, inout, 16: SRAM data bus.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, out, 1 each: SRAM controls, active-low.

Behaviour:
- Reset values:
  - WE_N, CE_N, OE_N, LB_N, UB_N = 1; o_SRAM_ADDR = 0; DQ tri-stated.
  - FIFO empty, so o_wr_ready = 1; o_rd_ready = 1.
  - o_rd_valid = 0, o_rd_data = 0, o_overflow = 0, FSM in IDLE.
  - Reset mid-access aborts immediately: controls deassert asynchronously, FIFO contents and pending read are discarded.
- Write FIFO:
  - Push when i_wr_valid & o_wr_ready.
  - o_wr_ready = !full, decoded from registered pointers/count.
  - Simultaneous push and pop is allowed in any state, including full (the pop frees the slot in the same cycle).
  - i_wr_valid while full and not popping: entry dropped, o_overflow set.
  - If a drop and i_clr_ovf coincide, set wins.
  - Pointers wrap modulo DEPTH.
- Read request:
  - Accepted only when o_rd_ready = 1: latch i_rd_addr, set pending, o_rd_ready = 0 from the next cycle.
  - i_rd_req with o_rd_ready = 0 is ignored.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, R_DONE.
- IDLE arbitration, evaluated each cycle:
  - FIFO full: start write.
  - Else read pending: start read.
  - Else FIFO non-empty: start write.
  - Else stay in IDLE with all controls deasserted.
- Write sequence:
  - Pop the head on the IDLE to W_SETUP transition.
  - W_SETUP (1 cycle): ADDR and DQ driven, CE_N = LB_N = UB_N = 0, WE_N = 1.
  - W_PULSE (WR_PULSE cycles): WE_N = 0.
  - W_HOLD (1 cycle): WE_N = 1, DQ still driven.
  - Then return to IDLE.
  - Cost: WR_PULSE + 2 cycles per write. Back-to-back writes incur one IDLE cycle between them.
- Read sequence:
  - R_ACC (RD_WAIT cycles): ADDR driven, DQ tri-stated, CE_N = OE_N = LB_N = UB_N = 0. On the final cycle, o_rd_data <= DQ.
  - R_DONE (1 cycle): controls deasserted, o_rd_valid = 1, pending cleared, o_rd_ready = 1 on the next cycle.
  - Latency: with the FSM idle and the FIFO not full, i_rd_req in cycle 0 yields o_rd_valid in cycle RD_WAIT + 2.
- Bus rules:
  - DQ is driven only in W_SETUP, W_PULSE and W_HOLD.
  - OE_N and WE_N are never low in the same cycle.
  - An access is never interrupted except by reset.
- Address width: addresses pass through unmodified. No increment or wrap is performed here.

Test Plan:
- Single write: push {addr 0x00005, data 0xBEEF} from IDLE -> WE_N low for exactly 2 cycles with ADDR = 0x00005, DQ = 0xBEEF, preceded and followed by 1 cycle WE_N = 1 with the same ADDR/DQ.
- Burst of 6 pushes on consecutive cycles (DEPTH = 4) -> o_wr_ready drops after the FIFO fills; pushes made while ready = 0 are dropped and o_overflow = 1; all accepted entries are written in order with no duplicates; i_clr_ovf clears the flag.
- Read of 0x00005 after the write, with a behavioural SRAM model -> o_rd_valid pulse exactly RD_WAIT + 2 = 4 cycles after i_rd_req, o_rd_data = 0xBEEF, DQ never driven by the DUT during R_ACC.
- i_rd_req while the FIFO holds 2 entries and a write is in flight -> the current write completes, the read is serviced next (before the queued write), then the queued write runs; a second i_rd_req during this time is ignored.
- FIFO full and a read pending simultaneously -> write is serviced first.
- Assert reset during W_PULSE -> WE_N = 1 and DQ released asynchronously; after release, o_wr_ready = 1, FIFO empty, FSM IDLE, no spurious writes.
